// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Redirect priorities are ordered so a plain >= compare picks the winner.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PRIO_NONE   = 2'd0,
        PRIO_BRANCH = 2'd1,
        PRIO_JUMP   = 2'd2,
        PRIO_EXC    = 2'd3
    } prio_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Pending-redirect register: holds the highest-priority unconsumed target.
// o_valid/o_target present the merge of the pending entry and this cycle's arrival.
module pc_redirect_latch
    import pc_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  prio_t       i_prio,
    input  logic [31:0] i_target,
    input  logic        i_clear,
    output logic        o_valid,
    output logic [31:0] o_target
);

    prio_t       r_prio;
    logic [31:0] r_target;
    logic        w_take_new;

    assign w_take_new = (i_prio != PRIO_NONE) && (i_prio >= r_prio);
    assign o_valid    = w_take_new || (r_prio != PRIO_NONE);
    assign o_target   = w_take_new ? i_target : r_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio   <= PRIO_NONE;
            r_target <= '0;
        end else if (i_clear) begin
            r_prio   <= PRIO_NONE;
        end else if (w_take_new) begin
            r_prio   <= i_prio;
            r_target <= i_target;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: picks the next PC, handshakes with instruction
// memory, honours stalls and hands delivered PCs to decode.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_mis;

    prio_t       w_prio;
    logic [31:0] w_tgt;
    logic        w_mis;
    logic        w_clear;
    logic        w_eff_valid;
    logic [31:0] w_eff_target;

    // A misaligned branch/jump target is promoted to an exception.
    always_comb begin
        w_prio = PRIO_NONE;
        w_tgt  = '0;
        w_mis  = 1'b0;
        if (exception) begin
            w_prio = PRIO_EXC;
            w_tgt  = EXC_VECTOR;
        end else if (jump) begin
            w_prio = PRIO_JUMP;
            w_tgt  = jump_target;
        end else if (branch_taken) begin
            w_prio = PRIO_BRANCH;
            w_tgt  = branch_target;
        end
        if (w_prio != PRIO_EXC && w_prio != PRIO_NONE && misaligned(w_tgt)) begin
            w_mis  = 1'b1;
            w_prio = PRIO_EXC;
            w_tgt  = EXC_VECTOR;
        end
    end

    // Nothing outstanding, or the outstanding fetch completes: consume.
    assign w_clear = (r_state != S_REQ) || imem_ack;

    pc_redirect_latch u_latch (
        .clk      (clk),
        .rst      (reset),
        .i_prio   (w_prio),
        .i_target (w_tgt),
        .i_clear  (w_clear),
        .o_valid  (w_eff_valid),
        .o_target (w_eff_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_BOOT;
            r_req   <= 1'b0;
            r_addr  <= RESET_VECTOR;
            r_valid <= 1'b0;
            r_pc    <= RESET_VECTOR;
            r_mis   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_mis   <= w_mis;
            unique case (r_state)
                S_BOOT, S_HOLD: begin
                    if (w_eff_valid)
                        r_addr <= w_eff_target;
                    r_state <= stall ? S_HOLD : S_REQ;
                    r_req   <= !stall;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (w_eff_valid) begin
                            r_addr <= w_eff_target;
                        end else begin
                            r_addr  <= r_addr + PC_STEP;
                            r_valid <= 1'b1;
                            r_pc    <= r_addr;
                        end
                        if (stall) begin
                            r_state <= S_HOLD;
                            r_req   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign instr_valid  = r_valid;
    assign instr_pc     = r_pc;
    assign misalign_err = r_mis;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal checks,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] EXV = 32'h0000_0080;
    localparam logic [31:0] RV2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch_taken, jump, exception, imem_ack;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, instr_valid, misalign_err;
    logic [31:0] imem_addr, instr_pc;
    logic        w2_req, w2_valid, w2_mis;
    logic [31:0] w2_addr, w2_pc;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .misalign_err  (misalign_err)
    );

    pc_fetch_sequencer #(.RESET_VECTOR(RV2)) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .jump          (1'b0),
        .jump_target   (32'h0),
        .exception     (1'b0),
        .imem_req      (w2_req),
        .imem_addr     (w2_addr),
        .imem_ack      (1'b1),
        .instr_valid   (w2_valid),
        .instr_pc      (w2_pc),
        .misalign_err  (w2_mis)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: "fetching" means a request is outstanding.
    bit          m_fetch;
    logic [31:0] m_pc;
    int          m_prank;
    logic [31:0] m_ptgt;
    bit          m_valid;
    logic [31:0] m_ipc;
    bit          m_mis;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch = 0;
        m_pc    = RV;
        m_prank = 0;
        m_ptgt  = '0;
        m_valid = 0;
        m_ipc   = RV;
        m_mis   = 0;
    endtask

    task automatic model_step();
        int          ar, er;
        logic [31:0] at, et;
        bit          mis;
        ar = 0;
        at = '0;
        if (exception) begin
            ar = 3; at = EXV;
        end else if (jump) begin
            ar = 2; at = jump_target;
        end else if (branch_taken) begin
            ar = 1; at = branch_target;
        end
        mis = (ar == 1 || ar == 2) && (at % 4 != 0);
        if (mis) begin
            ar = 3; at = EXV;
        end
        if (ar > 0 && ar >= m_prank) begin
            er = ar; et = at;
        end else begin
            er = m_prank; et = m_ptgt;
        end
        m_valid = 0;
        m_mis   = mis;
        if (!m_fetch) begin
            if (er > 0) m_pc = et;
            m_prank = 0;
            m_fetch = !stall;
        end else if (imem_ack) begin
            if (er > 0) begin
                m_pc = et;
            end else begin
                m_valid = 1;
                m_ipc   = m_pc;
                m_pc    = m_pc + 32'd4;
            end
            m_prank = 0;
            m_fetch = !stall;
        end else begin
            m_prank = er;
            m_ptgt  = et;
        end
    endtask

    task automatic compare_all();
        chk("imem_req",     {31'b0, imem_req},     {31'b0, m_fetch});
        chk("imem_addr",    imem_addr,             m_pc);
        chk("instr_valid",  {31'b0, instr_valid},  {31'b0, m_valid});
        chk("instr_pc",     instr_pc,              m_ipc);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    endtask

    task automatic step(input bit s, input bit br, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt, input bit e,
                        input bit a);
        stall         = s;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        exception     = e;
        imem_ack      = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit s, input bit a);
        step(s, 0, 32'h0, 0, 32'h0, 0, a);
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        t = $urandom();
        t[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    initial begin
        stall = 0; branch_taken = 0; jump = 0; exception = 0; imem_ack = 0;
        branch_target = '0; jump_target = '0;
        reset = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            RV);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_w2_pc", w2_pc,                RV2);
        reset = 0;
        compare_all();

        idle(0, 1);
        chk("lit_first_req", {31'b0, imem_req}, 32'd1);
        chk("lit_addr0",     imem_addr,         32'h0);
        chk("lit_w2_addr0",  w2_addr,           RV2);
        idle(0, 1);
        chk("lit_addr4",     imem_addr,         32'h4);
        chk("lit_pc0",       instr_pc,          32'h0);
        chk("lit_w2_wrap",   w2_addr,           32'h0);

        for (int k = 0; k < 3; k++) begin
            idle(0, 0);
            chk("lit_hold_addr", imem_addr, 32'h4);
        end
        idle(0, 1);
        chk("lit_addr8",  imem_addr,            32'h8);
        chk("lit_v4",     {31'b0, instr_valid}, 32'd1);
        chk("lit_pc4",    instr_pc,             32'h4);

        step(0, 1, 32'h40, 0, 32'h0, 0, 1);
        chk("lit_br_addr",   imem_addr,            32'h40);
        chk("lit_br_squash", {31'b0, instr_valid}, 32'd0);

        step(0, 1, 32'h300, 1, 32'h200, 1, 1);
        chk("lit_exc_addr", imem_addr, 32'h80);
        idle(0, 1);
        chk("lit_pc80", instr_pc, 32'h80);

        step(0, 0, 32'h0, 1, 32'hC, 0, 1);
        idle(1, 0);
        idle(1, 0);
        idle(1, 1);
        chk("lit_stall_pc",   instr_pc,          32'hC);
        chk("lit_stall_req",  {31'b0, imem_req}, 32'd0);
        chk("lit_stall_addr", imem_addr,         32'h10);
        idle(1, 0);
        chk("lit_stall_req2", {31'b0, imem_req}, 32'd0);
        idle(0, 0);
        chk("lit_resume_req",  {31'b0, imem_req}, 32'd1);
        chk("lit_resume_addr", imem_addr,         32'h10);

        step(0, 0, 32'h0, 1, 32'h41, 0, 1);
        chk("lit_mis_err",  {31'b0, misalign_err}, 32'd1);
        chk("lit_mis_addr", imem_addr,             32'h80);
        idle(0, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 reset = 1;
                #1;
                chk("lit_midrst_req",  {31'b0, imem_req}, 32'd0);
                chk("lit_midrst_addr", imem_addr,         RV);
                model_reset();
                stall = 0; branch_taken = 0; jump = 0; exception = 0;
                imem_ack = 0;
                @(negedge clk);
                reset = 0;
                compare_all();
            end
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, rnd_target(),
                 $urandom_range(0, 11) == 0, rnd_target(),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
